jk_counter_reg: RTL
===================

// Module: jk_counter_reg
// PURPOSE
//   WIDTH-bit register of JK cells with a per-bit JK mode plus up-count,
//   down-count and parallel-load modes. Generalises the single JK/T flip-flop
//   cell to a multi-bit register and counter for the flip-flop/counter library.
//   Sits between control logic and datapath as a general state/count register.
// PARAMETERS
//   WIDTH      8   register width in bits (>=2)
//   RST_VAL    0   value loaded on reset (WIDTH bits)
// PORTS
//   clk    in   1      rising-edge clock
//   cr     in   1      asynchronous active-low reset (clear to RST_VAL)
//   en     in   1      clock enable; low = hold in every mode
//   mode   in   2      00 JK, 01 count up, 10 count down, 11 parallel load
//   j      in   WIDTH  per-bit J (mode 00 only)
//   k      in   WIDTH  per-bit K (mode 00 only)
//   d      in   WIDTH  parallel load data (mode 11 only)
//   q      out  WIDTH  register state
//   q_bar  out  WIDTH  bitwise ~q, always exact complement
//   tc     out  1      terminal count, combinational from q and mode
//   wrap   out  1      registered 1-cycle pulse, count crossed boundary
// BEHAVIOUR
//   - Reset: cr low -> immediately q=RST_VAL, q_bar=~RST_VAL, wrap=0; overrides
//     clk/en, takes effect mid-count with no clock. First update on first
//     rising clk edge after cr rises.
//   - All updates on rising clk when cr=1 and en=1; en=0 -> q, wrap hold/clear
//     (wrap forced 0 on any edge with en=0).
//   - Mode 00, per bit i: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set;
//     J=1,K=1 toggle. Bits independent. wrap=0.
//   - Mode 01: q <= q+1 modulo 2^WIDTH, implemented as JK toggle chain
//     (bit i toggles when all lower bits are 1). q=all-ones -> 0, wrap=1 next.
//   - Mode 10: q <= q-1 modulo 2^WIDTH (bit i toggles when all lower bits 0).
//     q=0 -> all-ones, wrap=1 next.
//   - Mode 11: q <= d. wrap=0.
//   - Latency: one clock from inputs to q; wrap asserts the same edge q wraps,
//     visible for exactly one cycle.
//   - tc = (mode==01 && q==all-ones) || (mode==10 && q==0); else 0. tc ignores en.
//   - Mode change between cycles is legal; new mode applies on next edge, no
//     residual state. j/k/d ignored outside their modes.
//   - No X propagation from unused inputs; all outputs defined after reset.
// CONFIGURATION
//   JKC_SAT_EN defined: modes 01/10 saturate: all-ones held in up mode,
//     0 held in down mode; wrap never asserts (tied 0); tc unchanged.
//   JKC_SAT_EN undefined: modulo wrap as above, wrap pulse active.
// TESTING (WIDTH=4, RST_VAL=0 unless noted)
//   1 cr=0 at t=2 with clk idle -> q=0000, q_bar=1111, wrap=0 immediately.
//   2 mode=00, j=1010,k=0110 from q=0011 -> q=1001; then j=k=1111 -> q=0110.
//   3 mode=01, en=1, 17 edges from 0 -> q seq 1..15,0,1; tc=1 at q=1111;
//     wrap=1 only the cycle q becomes 0 (with JKC_SAT_EN: q stays 1111, wrap=0).
//   4 mode=10 from 0001, 2 edges -> q=0000 then 1111, wrap pulse on second.
//   5 mode=11 d=1100 then en=0 with mode=01 for 3 edges -> q holds 1100.
//   6 mode=01 counting at q=0101, cr pulsed low mid-cycle -> q=0000 at once,
//     counting resumes 0001 on first edge after cr=1.

Source files
------------

// File: rtl/jk_counter_reg.sv
// ---------------------------------------------------------------------------
// jk_counter_reg
//
// WIDTH-bit register built from JK cells. Every bit is updated through the
// same JK next-state equation  q+ = (J & ~q) | (~K & q); the operating mode
// only changes which J/K pair each cell sees:
//   mode 00  JK       : external per-bit j/k
//   mode 01  count up : J=K=1 on bit i when all lower bits are 1
//   mode 10  count dn : J=K=1 on bit i when all lower bits are 0
//   mode 11  load     : J=d, K=~d (forces each cell to d)
//
// Optional build macro:
//   JKC_SAT_EN  - count modes saturate instead of wrapping. Up mode holds
//                 all-ones, down mode holds zero, and wrap never asserts.
//                 tc is unaffected. Without the macro counting wraps modulo
//                 2^WIDTH and wrap pulses for one cycle on each wrap.
//
// Parameters:
//   WIDTH    register width (>= 2)
//   RST_VAL  value forced while cr is low
//
// Ports:
//   clk    in   1      rising-edge clock
//   cr     in   1      asynchronous active-low clear to RST_VAL
//   en     in   1      clock enable; low holds q and clears wrap
//   mode   in   2      00 JK, 01 up, 10 down, 11 parallel load
//   j      in   WIDTH  per-bit J (mode 00 only)
//   k      in   WIDTH  per-bit K (mode 00 only)
//   d      in   WIDTH  parallel load data (mode 11 only)
//   q      out  WIDTH  register state
//   q_bar  out  WIDTH  bitwise complement of q
//   tc     out  1      terminal count, combinational from q and mode
//   wrap   out  1      registered one-cycle pulse when a count wraps
// ---------------------------------------------------------------------------
module jk_counter_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             cr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_UP = 2'b01,
    MODE_DN = 2'b10,
    MODE_LD = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;

  // Toggle enables for the two count directions (one per cell).
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             up_acc;
  logic             dn_acc;

  // Effective J/K presented to each cell after mode selection.
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;

  logic             all_ones;
  logic             all_zeros;
  logic             at_bound;

  assign mode_s    = mode_e'(mode);
  assign all_ones  = &q_q;
  assign all_zeros = ~|q_q;

  // Ripple toggle chains. The accumulators carry "all lower bits are 1"
  // (up) and "all lower bits are 0" (down) from bit 0 upward; bit 0
  // always toggles when counting.
  always_comb begin
    up_t   = '0;
    dn_t   = '0;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_acc;
      dn_t[i] = dn_acc;
      up_acc  = up_acc & q_q[i];
      dn_acc  = dn_acc & ~q_q[i];
    end
  end

  // Terminal count looks only at mode and current state; en is ignored
  // so control logic can see the boundary before enabling the edge.
  always_comb begin
    at_bound = 1'b0;
    case (mode_s)
      MODE_UP: at_bound = all_ones;
      MODE_DN: at_bound = all_zeros;
      default: at_bound = 1'b0;
    endcase
  end

  assign tc = at_bound;

  // Mode selection onto the cell J/K inputs. Inputs that do not belong to
  // the active mode never reach a cell, so they cannot leak X into q.
  always_comb begin
    j_eff = '0;
    k_eff = '0;
    case (mode_s)
      MODE_JK: begin
        j_eff = j;
        k_eff = k;
      end
      MODE_UP: begin
`ifdef JKC_SAT_EN
        // At all-ones every cell holds instead of rolling over.
        if (!all_ones) begin
          j_eff = up_t;
          k_eff = up_t;
        end
`else
        j_eff = up_t;
        k_eff = up_t;
`endif
      end
      MODE_DN: begin
`ifdef JKC_SAT_EN
        // At zero every cell holds instead of rolling under.
        if (!all_zeros) begin
          j_eff = dn_t;
          k_eff = dn_t;
        end
`else
        j_eff = dn_t;
        k_eff = dn_t;
`endif
      end
      MODE_LD: begin
        // J=d, K=~d sets or clears each cell to d regardless of q.
        j_eff = d;
        k_eff = ~d;
      end
      default: begin
        j_eff = '0;
        k_eff = '0;
      end
    endcase
  end

  // Shared JK cell equation and enable gating.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (en) begin
      q_d = (j_eff & ~q_q) | (~k_eff & q_q);
`ifdef JKC_SAT_EN
      wrap_d = 1'b0;
`else
      // Being at the boundary in a count mode on an enabled edge is exactly
      // the edge on which q rolls over.
      wrap_d = at_bound;
`endif
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;
  assign wrap  = wrap_q;

endmodule
